// File: rtl/payload_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | payload_checker : regenerates the test payload stream and checks it.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

module lfsr #(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(32'h8020_0003)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_seed_dv,
  input  logic [NUM_BITS-1:0] i_seed_data,
  output logic [NUM_BITS-1:0] o_lfsr_data
);

  logic [NUM_BITS-1:0] state_q, state_d;

  // XNOR feedback: the all-zero reset state is a legal member of the sequence
  always_comb begin
    state_d = state_q;
    if (i_seed_dv)
      state_d = i_seed_data;
    else if (i_enable)
      state_d = {state_q[NUM_BITS-2:0], ~^(state_q & TAPS)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= '0;
    else          state_q <= state_d;
  end

  assign o_lfsr_data = state_q;

endmodule

module payload_checker #(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] COUNT_INIT = 32'h01234567
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rst_seed,
  input  logic [31:0]      i_seed_data,
  input  logic             i_data_valid,
  input  logic [7:0]       i_data,
  output logic             o_pkt_done,
  output logic             o_pkt_ok,
  output logic [15:0]      o_pkt_len,
  output logic [15:0]      o_first_err_idx,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_bad_pkt_cnt,
  output logic [CNT_W-1:0] o_byte_err_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNT = 2'd1, S_LFSR = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              pkt_err_q, pkt_err_d;
  logic [15:0]       err_idx_q, err_idx_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic [15:0]       pkt_len_q, pkt_len_d;
  logic [15:0]       first_err_q, first_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0]  byte_err_q, byte_err_d;

  logic              lfsr_en;
  logic [31:0]       lfsr_data;
  logic [7:0]        exp_byte;
  logic              mismatch;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  lfsr #(.NUM_BITS(32)) u_lfsr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (lfsr_en),
    .i_seed_dv   (i_rst_seed),
    .i_seed_data (i_seed_data),
    .o_lfsr_data (lfsr_data)
  );

  always_comb begin
    exp_byte = count_q[31:24];
    case (state_q)
      S_COUNT: begin
        case (idx_q[1:0])
          2'd1:    exp_byte = count_q[23:16];
          2'd2:    exp_byte = count_q[15:8];
          default: exp_byte = count_q[7:0];
        endcase
      end
      S_LFSR: begin
        case (ptr_q)
          2'd0:    exp_byte = word_q[31:24];
          2'd1:    exp_byte = word_q[23:16];
          2'd2:    exp_byte = word_q[15:8];
          default: exp_byte = word_q[7:0];
        endcase
      end
      default: exp_byte = count_q[31:24];
    endcase
    mismatch = i_data_valid && (i_data != exp_byte);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_d      = word_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    pkt_err_d   = pkt_err_q;
    err_idx_d   = err_idx_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = pkt_ok_q;
    pkt_len_d   = pkt_len_q;
    first_err_d = first_err_q;
    pkt_cnt_d   = pkt_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    byte_err_d  = byte_err_q;
    lfsr_en     = 1'b0;

    if (i_rst_seed) begin
      count_d = COUNT_INIT;
      state_d = S_IDLE;
    end else begin
      if (mismatch)
        byte_err_d = cnt_inc(byte_err_q);

      if (state_q == S_IDLE) begin
        if (i_data_valid) begin
          idx_d     = 16'd1;
          pkt_err_d = mismatch;
          err_idx_d = mismatch ? 16'd0 : 16'hFFFF;
          state_d   = S_COUNT;
        end
      end else if (i_data_valid) begin
        idx_d = (&idx_q) ? idx_q : idx_q + 16'd1;
        if (mismatch && !pkt_err_q) begin
          pkt_err_d = 1'b1;
          err_idx_d = idx_q;
        end
        // A word is fetched on the last count byte and after every 4th LFSR byte
        if ((state_q == S_COUNT && idx_q[1:0] == 2'd3) ||
            (state_q == S_LFSR && ptr_q == 2'd3)) begin
          word_d  = lfsr_data;
          lfsr_en = 1'b1;
        end
        if (state_q == S_COUNT) begin
          if (idx_q[1:0] == 2'd3) begin
            ptr_d   = 2'd0;
            state_d = S_LFSR;
          end
        end else begin
          ptr_d = ptr_q + 2'd1;
        end
      end else begin
        pkt_done_d  = 1'b1;
        pkt_ok_d    = !pkt_err_q;
        pkt_len_d   = idx_q;
        first_err_d = err_idx_q;
        pkt_cnt_d   = cnt_inc(pkt_cnt_q);
        if (pkt_err_q)
          bad_cnt_d = cnt_inc(bad_cnt_q);
        // Short packets never reached the payload, so the count is not consumed
        if (state_q == S_LFSR)
          count_d = count_q + 32'd1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= COUNT_INIT;
      word_q      <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      pkt_err_q   <= 1'b0;
      err_idx_q   <= 16'hFFFF;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_len_q   <= '0;
      first_err_q <= 16'hFFFF;
      pkt_cnt_q   <= '0;
      bad_cnt_q   <= '0;
      byte_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      pkt_err_q   <= pkt_err_d;
      err_idx_q   <= err_idx_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_len_q   <= pkt_len_d;
      first_err_q <= first_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      byte_err_q  <= byte_err_d;
    end
  end

  assign o_pkt_done      = pkt_done_q;
  assign o_pkt_ok        = pkt_ok_q;
  assign o_pkt_len       = pkt_len_q;
  assign o_first_err_idx = first_err_q;
  assign o_pkt_cnt       = pkt_cnt_q;
  assign o_bad_pkt_cnt   = bad_cnt_q;
  assign o_byte_err_cnt  = byte_err_q;

endmodule

`default_nettype wire

// File: tb/tb_payload_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_payload_checker : directed self-checking bench for payload_checker.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

module tb_payload_checker;

  localparam logic [31:0] COUNT_INIT = 32'h01234567;
  localparam logic [31:0] SEED       = 32'hACE1ACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_seed = 1'b0;
  logic [31:0] seed_data = '0;
  logic        data_valid = 1'b0;
  logic [7:0]  data = '0;
  logic        pkt_done, pkt_ok;
  logic [15:0] pkt_len, first_err_idx;
  logic [15:0] pkt_cnt, bad_pkt_cnt, byte_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Generator model: packet count and the next word the LFSR will hand out
  logic [31:0] m_count, m_next;
  logic [7:0]  pkt[$];

  always #5 clk = ~clk;

  payload_checker #(.CNT_W(16), .COUNT_INIT(COUNT_INIT)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rst_seed      (rst_seed),
    .i_seed_data     (seed_data),
    .i_data_valid    (data_valid),
    .i_data          (data),
    .o_pkt_done      (pkt_done),
    .o_pkt_ok        (pkt_ok),
    .o_pkt_len       (pkt_len),
    .o_first_err_idx (first_err_idx),
    .o_pkt_cnt       (pkt_cnt),
    .o_bad_pkt_cnt   (bad_pkt_cnt),
    .o_byte_err_cnt  (byte_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  task automatic reseed(input logic [31:0] seed);
    rst_seed  = 1'b1;
    seed_data = seed;
    @(posedge clk); #1;
    rst_seed  = 1'b0;
    m_count   = COUNT_INIT;
    m_next    = seed;
  endtask

  task automatic build(input int len, input int flip);
    logic [31:0] cur;
    int p;
    cur = '0;
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 4) begin
        pkt.push_back(m_count[31-8*i -: 8]);
        if (i == 3) begin
          cur    = m_next;
          m_next = step(m_next);
        end
      end else begin
        p = (i - 4) % 4;
        pkt.push_back(cur[31-8*p -: 8]);
        if (p == 3) begin
          cur    = m_next;
          m_next = step(m_next);
        end
      end
    end
    if (len >= 4) m_count = m_count + 32'd1;
    if (flip >= 0) pkt[flip] = pkt[flip] ^ 8'h01;
  endtask

  // Leaves the bench one cycle after the gap, where o_pkt_done is visible
  task automatic send(input int len, input int flip);
    build(len, flip);
    for (int i = 0; i < len; i++) begin
      data_valid = 1'b1;
      data       = pkt[i];
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lens[5];
    logic saw_done;
    lens = '{4, 5, 7, 8, 9};
    m_count = COUNT_INIT;
    m_next  = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_done",     pkt_done,      0);
    check("rst_ok",       pkt_ok,        0);
    check("rst_len",      pkt_len,       0);
    check("rst_first",    first_err_idx, 16'hFFFF);
    check("rst_pkt_cnt",  pkt_cnt,       0);
    check("rst_bad_cnt",  bad_pkt_cnt,   0);
    check("rst_byte_err", byte_err_cnt,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First loopback packet
    reseed(SEED);
    send(64, -1);
    check("p64_done",  pkt_done,      1);
    check("p64_ok",    pkt_ok,        1);
    check("p64_len",   pkt_len,       64);
    check("p64_first", first_err_idx, 16'hFFFF);
    @(posedge clk); #1;
    check("p64_done_pulse", pkt_done, 0);

    // 99 more back-to-back packets, boundary lengths then random
    for (int n = 0; n < 99; n++)
      send((n < 5) ? lens[n] : int'($urandom_range(10, 300)), -1);
    check("run_pkt_cnt",  pkt_cnt,      100);
    check("run_bad_cnt",  bad_pkt_cnt,  0);
    check("run_byte_err", byte_err_cnt, 0);

    // Single flipped bit in packet 3
    pulse_reset();
    reseed(SEED);
    send(20, -1);
    send(33, -1);
    send(40, 10);
    check("err_ok",    pkt_ok,        0);
    check("err_first", first_err_idx, 10);
    check("err_len",   pkt_len,       40);
    check("err_bytes", byte_err_cnt,  1);
    send(17, -1);
    check("after_ok4", pkt_ok, 1);
    send(64, -1);
    check("after_ok5",    pkt_ok,       1);
    check("err_pkt_cnt",  pkt_cnt,      5);
    check("err_bad_cnt",  bad_pkt_cnt,  1);
    check("err_byte_tot", byte_err_cnt, 1);

    // Short packet does not advance the count
    pulse_reset();
    reseed(SEED);
    send(3, -1);
    check("short_done", pkt_done, 1);
    check("short_ok",   pkt_ok,   1);
    check("short_len",  pkt_len,  3);
    send(64, -1);
    check("after_short_ok",    pkt_ok,        1);
    check("after_short_first", first_err_idx, 16'hFFFF);
    check("after_short_cnt",   pkt_cnt,       2);

    // Seed reset at byte 20 abandons the packet silently
    build(50, -1);
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1;
      data       = pkt[i];
      @(posedge clk); #1;
    end
    data       = pkt[20];
    rst_seed   = 1'b1;
    seed_data  = SEED;
    @(posedge clk); #1;
    rst_seed   = 1'b0;
    data_valid = 1'b0;
    m_count    = COUNT_INIT;
    m_next     = SEED;
    saw_done   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (pkt_done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_cnt",     pkt_cnt,  2);
    send(48, -1);
    check("resend_ok",  pkt_ok,  1);
    check("resend_cnt", pkt_cnt, 3);

    // Asynchronous reset in the middle of a packet
    build(30, -1);
    for (int i = 0; i < 10; i++) begin
      data_valid = 1'b1;
      data       = pkt[i];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_pkt_cnt",  pkt_cnt,       0);
    check("arst_bad_cnt",  bad_pkt_cnt,   0);
    check("arst_byte_err", byte_err_cnt,  0);
    check("arst_first",    first_err_idx, 16'hFFFF);
    check("arst_done",     pkt_done,      0);
    data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    reseed(SEED);
    send(12, -1);
    check("arst_idle_ok",  pkt_ok,  1);
    check("arst_idle_cnt", pkt_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/payload_checker.md
Name: payload_checker

Overview:
- Receive-side checker for the test payload stream emitted by the transmit-side payload generator. It sits downstream of the RGMII receive path and deframer.
- It regenerates the expected byte stream: a 4-byte big-endian packet count, then successive 32-bit words from the shared `lfsr` module, sent MSB first.
- It compares the regenerated stream byte-by-byte against received bytes and reports per-packet pass/fail plus running statistics.
- The expected stream follows the generator's packet and LFSR bookkeeping exactly, so a clean loopback reports zero errors indefinitely.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.
- COUNT_INIT, 32'h01234567, expected packet count after seed reset.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rst_seed  in  1  resynchronisation pulse, same meaning as the generator's seed-reset input.
- i_seed_data  in  32  LFSR seed, loaded while i_rst_seed=1.
- i_data_valid  in  1  high for every payload byte; a low cycle ends the packet; bytes in a packet are contiguous.
- i_data  in  8  received payload byte.
- o_pkt_done  out  1  one-cycle pulse after each packet ends.
- o_pkt_ok  out  1  valid with o_pkt_done; 1 = every byte of the packet matched.
- o_pkt_len  out  16  byte count of the finished packet, valid with o_pkt_done; saturates at 16'hFFFF.
- o_first_err_idx  out  16  byte index of the first mismatch in the finished packet; 16'hFFFF if none.
- o_pkt_cnt  out  CNT_W  packets checked.
- o_bad_pkt_cnt  out  CNT_W  packets with at least one mismatch.
- o_byte_err_cnt  out  CNT_W  total mismatched bytes.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - all outputs 0, except o_first_err_idx=16'hFFFF;
  - state=S_IDLE; expected count = COUNT_INIT.
- Internal generator: one `lfsr` instance with NUM_BITS=32, sharing i_rst_seed and i_seed_data; its enable is driven by the checker.
- Expected-word load: capture the lfsr output into the expected-word register and pulse the lfsr enable for one cycle. Loads are at least 4 cycles apart.
- i_rst_seed=1 (any state, takes priority):
  - expected count := COUNT_INIT;
  - lfsr reseeds;
  - state := S_IDLE, any packet in flight is abandoned with no o_pkt_done;
  - statistics counters hold their values.
- S_IDLE:
  - on i_data_valid=1: compare i_data to count[31:24], set byte index to 1, go to S_COUNT.
- S_COUNT (receiving count bytes 1..3, compared to count[23:16], [15:8], [7:0]):
  - on the byte at index 3, load an expected word and go to S_LFSR.
  - i_data_valid=0 before index 3: packet ends short. Expected count does not advance; no expected word is loaded.
- S_LFSR:
  - each byte is compared against the current expected word, MSB byte first;
  - after the 4th byte of a word, load the next word, even if that byte is the last of the packet;
  - on i_data_valid=0: expected count += 1 (mod 2^32), return to S_IDLE.
  - A partially received word is therefore consumed, and the next packet's first LFSR word is the one following the last loaded word. This matches the generator.
- Mismatch on a byte:
  - o_byte_err_cnt += 1, saturating;
  - the first mismatch of the packet latches its index.
- Packet end (first cycle with i_data_valid=0 after any valid byte), outputs registered, visible on the next cycle:
  - o_pkt_done=1 for exactly one cycle;
  - o_pkt_ok, o_pkt_len and o_first_err_idx update and hold until the next o_pkt_done;
  - o_pkt_cnt += 1; o_bad_pkt_cnt += 1 if any mismatch; both saturate.
- Short packets (<4 bytes) are still reported.
- No resynchronisation on error: a dropped or extra packet corrupts all later LFSR expectations until the next i_rst_seed.

Test Plan:
- Seed 32'hACE1ACE1 on both sides, 64-byte loopback packet from the generator → first 4 bytes checked as 01 23 45 67; o_pkt_done pulse, o_pkt_ok=1, o_pkt_len=64, o_first_err_idx=FFFF.
- 100 back-to-back loopback packets with lengths 4, 5, 7, 8, 9 and random 10..300 → o_pkt_cnt=100, o_bad_pkt_cnt=0, o_byte_err_cnt=0. This confirms partial-word skipping and boundary-word skipping.
- Flip bit 0 of byte 10 in packet 3 → packet 3: o_pkt_ok=0, o_first_err_idx=10; o_byte_err_cnt=1; packets 4+ pass.
- 3-byte packet 01 23 45, then a full packet with count 01234567 → first packet: o_pkt_ok=1, o_pkt_len=3; second packet passes, since the count did not advance.
- Assert i_rst_seed mid-packet at byte 20, then reseed generator and resend → no o_pkt_done for the aborted packet; the next packet passes with count 01234567.
- Assert i_rst_n low mid-packet → all counters 0 asynchronously, o_first_err_idx=FFFF, state idle.
